// File: rtl/vga_mode_ctrl.sv
// Run-time video-mode controller: holds the active VGA mode, swaps timing at a
// frame boundary and keeps the sync generator in reset until the pixel PLL re-locks.
module vga_mode_ctrl #(
  parameter int DEFAULT_MODE  = 2,
  parameter int LOCK_STABLE   = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int FRAME_TIMEOUT = 2000000,
  parameter int CNT_W         = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_req,
  input  logic [1:0]  mode_sel,
  input  logic        frame_end,
  input  logic        pll_locked,
  output logic        mode_ack,
  output logic        mode_busy,
  output logic        mode_err,
  output logic [1:0]  cur_mode,
  output logic [1:0]  pclk_sel,
  output logic        sync_rst,
  output logic [11:0] h_active,
  output logic [11:0] h_fp,
  output logic [11:0] h_sync,
  output logic [11:0] h_bp,
  output logic [11:0] v_active,
  output logic [11:0] v_fp,
  output logic [11:0] v_sync,
  output logic [11:0] v_bp,
  output logic        hs_pol,
  output logic        vs_pol
);

  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam logic [1:0] DEF_M = 2'(DEFAULT_MODE);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_FRAME = 3'd1;
  localparam logic [2:0] SWITCH     = 3'd2;
  localparam logic [2:0] WAIT_LOCK  = 3'd3;
  localparam logic [2:0] RELEASE    = 3'd4;

  // Packed timing word: {h act,fp,sync,bp, v act,fp,sync,bp, hs_pol, vs_pol}
  function automatic logic [97:0] mode_timing(input logic [1:0] m);
    logic [97:0] t;
    case (m)
      2'd0:    t = {12'd640,  12'd16,  12'd96,  12'd48,  12'd480, 12'd10, 12'd2, 12'd33, 1'b0, 1'b0};
      2'd1:    t = {12'd800,  12'd40,  12'd128, 12'd88,  12'd600, 12'd1,  12'd4, 12'd23, 1'b1, 1'b1};
      2'd2:    t = {12'd1024, 12'd24,  12'd136, 12'd160, 12'd768, 12'd3,  12'd6, 12'd29, 1'b0, 1'b0};
      default: t = {12'd1280, 12'd110, 12'd40,  12'd220, 12'd720, 12'd5,  12'd5, 12'd20, 1'b1, 1'b1};
    endcase
    return t;
  endfunction

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [STB_W-1:0] stable;
  logic             pending;
  logic [1:0]       pend_mode;
  logic [97:0]      timing;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      stable    <= '0;
      pending   <= 1'b0;
      pend_mode <= DEF_M;
      cur_mode  <= DEF_M;
      timing    <= mode_timing(DEF_M);
      sync_rst  <= 1'b1;
      mode_ack  <= 1'b0;
      mode_err  <= 1'b0;
    end else begin
      mode_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (mode_req) begin
            // A failed previous switch forces a full retry even for the same mode
            if (mode_sel == cur_mode && !mode_err) begin
              mode_ack <= 1'b1;
            end else begin
              pend_mode <= mode_sel;
              pending   <= 1'b1;
              cnt       <= '0;
              state     <= WAIT_FRAME;
            end
          end
        end
        WAIT_FRAME: begin
          if (frame_end || cnt == CNT_W'(FRAME_TIMEOUT - 1)) begin
            cur_mode <= pend_mode;
            timing   <= mode_timing(pend_mode);
            sync_rst <= 1'b1;
            mode_err <= 1'b0;
            cnt      <= '0;
            state    <= SWITCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SWITCH: begin
          cnt    <= '0;
          stable <= '0;
          state  <= WAIT_LOCK;
        end
        WAIT_LOCK: begin
          // Lock qualification wins over a timeout landing on the same cycle
          if (pll_locked && stable == STB_W'(LOCK_STABLE - 1)) begin
            sync_rst <= 1'b0;
            mode_ack <= pending;
            pending  <= 1'b0;
            stable   <= '0;
            state    <= RELEASE;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            mode_err <= 1'b1;
            mode_ack <= pending;
            pending  <= 1'b0;
            stable   <= '0;
            state    <= IDLE;
          end else begin
            cnt    <= cnt + 1'b1;
            stable <= pll_locked ? stable + 1'b1 : '0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mode_busy = (state != IDLE);
  assign pclk_sel  = cur_mode;
  assign {h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp, hs_pol, vs_pol} = timing;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Bench for vga_mode_ctrl: event-level reference model compared every cycle,
// plus hand-computed latency and value checks for the directed scenarios.
module tb_vga_mode_ctrl;
  localparam int LS = 16;
  localparam int LT = 200;
  localparam int FT = 300;

  logic clk = 1'b0, rst = 1'b0;
  logic mode_req = 1'b0, frame_end = 1'b0, pll_locked = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic mode_ack, mode_busy, mode_err, sync_rst, hs_pol, vs_pol;
  logic [1:0] cur_mode, pclk_sel;
  logic [11:0] h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp;

  vga_mode_ctrl #(.DEFAULT_MODE(2), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT),
                  .FRAME_TIMEOUT(FT), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .mode_req(mode_req), .mode_sel(mode_sel),
    .frame_end(frame_end), .pll_locked(pll_locked), .mode_ack(mode_ack),
    .mode_busy(mode_busy), .mode_err(mode_err), .cur_mode(cur_mode),
    .pclk_sel(pclk_sel), .sync_rst(sync_rst), .h_active(h_active), .h_fp(h_fp),
    .h_sync(h_sync), .h_bp(h_bp), .v_active(v_active), .v_fp(v_fp),
    .v_sync(v_sync), .v_bp(v_bp), .hs_pol(hs_pol), .vs_pol(vs_pol));

  always #5 clk = ~clk;

  int T_HA [4] = '{640, 800, 1024, 1280};
  int T_HF [4] = '{16, 40, 24, 110};
  int T_HS [4] = '{96, 128, 136, 40};
  int T_HB [4] = '{48, 88, 160, 220};
  int T_VA [4] = '{480, 600, 768, 720};
  int T_VF [4] = '{10, 1, 3, 5};
  int T_VS [4] = '{2, 4, 6, 5};
  int T_VB [4] = '{33, 23, 29, 20};
  int T_POS[4] = '{0, 1, 0, 1};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int n;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks which phase of a mode change we are in and
  // what the user-visible outputs must be.
  typedef struct packed {
    logic [1:0] mode, tgt;
    logic srst, busy, ack, err, pend;
    logic in_frame, in_swap, in_lock, in_rel;
    int run, age;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s = '0;
    s.mode = 2'd2; s.tgt = 2'd2;
    s.srst = 1'b1; s.busy = 1'b1; s.in_lock = 1'b1;
    return s;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s_in, input logic req, input logic [1:0] sel,
                                    input logic fe, input logic lk);
    mdl_t s;
    s = s_in;
    s.ack = 1'b0;
    if (s.in_rel) begin
      s.in_rel = 1'b0; s.busy = 1'b0;
    end else if (s.in_swap) begin
      s.in_swap = 1'b0; s.in_lock = 1'b1; s.run = 0; s.age = 0;
    end else if (s.in_lock) begin
      s.run = lk ? s.run + 1 : 0;
      if (s.run == LS) begin
        s.in_lock = 1'b0; s.in_rel = 1'b1; s.srst = 1'b0; s.ack = s.pend; s.pend = 1'b0;
      end else if (s.age == LT - 1) begin
        s.in_lock = 1'b0; s.busy = 1'b0; s.err = 1'b1; s.ack = s.pend; s.pend = 1'b0;
      end else s.age = s.age + 1;
    end else if (s.in_frame) begin
      if (fe || s.age == FT - 1) begin
        s.in_frame = 1'b0; s.in_swap = 1'b1; s.mode = s.tgt; s.srst = 1'b1; s.err = 1'b0;
      end else s.age = s.age + 1;
    end else if (req) begin
      if (sel == s.mode && !s.err) s.ack = 1'b1;
      else begin
        s.tgt = sel; s.pend = 1'b1; s.in_frame = 1'b1; s.age = 0; s.busy = 1'b1;
      end
    end
    return s;
  endfunction

  mdl_t m;
  always @(posedge clk or posedge rst) begin
    if (rst) m <= mdl_reset();
    else     m <= mdl_step(m, mode_req, mode_sel, frame_end, pll_locked);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", mode_ack, m.ack);
      check("busy", mode_busy, m.busy);
      check("err", mode_err, m.err);
      check("cur_mode", cur_mode, m.mode);
      check("pclk_sel", pclk_sel, m.mode);
      check("sync_rst", sync_rst, m.srst);
      check("h_active", h_active, T_HA[m.mode]);
      check("h_fp", h_fp, T_HF[m.mode]);
      check("h_sync", h_sync, T_HS[m.mode]);
      check("h_bp", h_bp, T_HB[m.mode]);
      check("v_active", v_active, T_VA[m.mode]);
      check("v_fp", v_fp, T_VF[m.mode]);
      check("v_sync", v_sync, T_VS[m.mode]);
      check("v_bp", v_bp, T_VB[m.mode]);
      check("hs_pol", hs_pol, T_POS[m.mode]);
      check("vs_pol", vs_pol, T_POS[m.mode]);
    end
  end

  task automatic req_pulse(input logic [1:0] sel);
    mode_req = 1'b1; mode_sel = sel;
    @(negedge clk);
    mode_req = 1'b0;
  endtask

  // frame_end pulse; returns with n = 1 at the SWITCH cycle
  task automatic fe_pulse();
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    n = 1;
  endtask

  task automatic wait_ack(input int limit);
    while (!mode_ack && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cur_mode", cur_mode, 2);
    check("rst_h_active", h_active, 1024);
    check("rst_sync_rst", sync_rst, 1);
    check("rst_busy", mode_busy, 1);
    check("rst_ack", mode_ack, 0);

    // 1: boot, PLL locks from cycle 3 after reset release
    rst = 1'b0;
    n = 0;
    while (sync_rst && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 3) pll_locked = 1'b1;
    end
    check("boot_release_cycle", n, 19);
    check("boot_mode", cur_mode, 2);
    @(negedge clk);

    // 2: same-mode request acks next cycle
    req_pulse(2'd2);
    check("same_ack", mode_ack, 1);
    check("same_sync_rst", sync_rst, 0);
    @(negedge clk);
    check("same_ack_1cyc", mode_ack, 0);
    pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    pll_locked = 1'b1;
    @(negedge clk);

    // 3: switch to mode 0, busy request dropped mid-wait
    req_pulse(2'd0);
    repeat (49) @(negedge clk);
    req_pulse(2'd3);
    repeat (48) @(negedge clk);
    fe_pulse();
    check("sw_h_active", h_active, 640);
    check("sw_v_bp", v_bp, 33);
    check("sw_hs_pol", hs_pol, 0);
    check("sw_sync_rst", sync_rst, 1);
    wait_ack(100);
    check("switch_latency", n, 18);
    @(negedge clk);

    // 4: lock glitch after 10 stable cycles restarts qualification
    req_pulse(2'd1);
    repeat (5) @(negedge clk);
    fe_pulse();
    repeat (11) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    pll_locked = 1'b1;
    n = 13;
    wait_ack(100);
    check("glitch_latency", n, 29);
    check("glitch_mode", cur_mode, 1);
    @(negedge clk);

    // 5: PLL never locks -> error and ack at timeout; same-mode retry
    req_pulse(2'd3);
    repeat (3) @(negedge clk);
    pll_locked = 1'b0;
    fe_pulse();
    wait_ack(400);
    check("timeout_latency", n, LT + 2);
    check("timeout_err", mode_err, 1);
    check("timeout_sync_rst", sync_rst, 1);
    @(negedge clk);
    pll_locked = 1'b1;
    req_pulse(2'd3);
    check("retry_busy", mode_busy, 1);
    repeat (2) @(negedge clk);
    fe_pulse();
    check("retry_err_clr", mode_err, 0);
    wait_ack(100);
    check("retry_latency", n, 18);
    @(negedge clk);

    // 6: request with coincident frame_end, then frame timeout, then reset mid-lock
    mode_req = 1'b1; mode_sel = 2'd0; frame_end = 1'b1;
    @(negedge clk);
    mode_req = 1'b0; frame_end = 1'b0;
    n = 1;
    while (cur_mode != 2'd0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout_latency", n, FT + 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mode", cur_mode, 2);
    check("midrst_h_active", h_active, 1024);
    check("midrst_busy", mode_busy, 1);
    check("midrst_sync_rst", sync_rst, 1);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("midrst_released", sync_rst, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
